// File: rtl/execute_muldiv_pkg.sv
// Shared types, func3 op codes and sign helpers for the execute-stage
// RV32M multiply/divide unit.
package execute_muldiv_pkg;

    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic [31:0] neg32_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] neg64_if(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit beside the ALU: shift-add multiplier and
// restoring divider on magnitudes, 32 cycles per op, stalls the front end.
module execute_muldiv_unit
    import execute_muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [2:0]  func3,
    input  logic        flush,
    output logic        stallRequest,
    output logic        busy,
    output logic        resultValid,
    output logic [31:0] result
);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [2:0]  op_q;
    logic [31:0] opb_q;    // multiplicand or divisor magnitude
    logic [63:0] acc_q;    // {hi, lo} product, or {remainder, dividend/quotient}
    logic        neg_q;    // final result must be negated
    logic [31:0] result_q;
    logic        valid_q;

    // Operand decode at issue
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;
    logic        div_zero, div_ovf;
    logic [31:0] special_res;

    assign sa    = a_is_signed(func3) & operandA[31];
    assign sb    = b_is_signed(func3) & operandB[31];
    assign mag_a = neg32_if(operandA, sa);
    assign mag_b = neg32_if(operandB, sb);

    assign div_zero = (operandB == 32'd0);
    assign div_ovf  = ((func3 == F3_DIV) || (func3 == F3_REM)) &&
                      (operandA == 32'h8000_0000) && (operandB == 32'hFFFF_FFFF);

    always_comb begin
        special_res = 32'd0;
        if (div_zero)
            special_res = func3[1] ? operandA : 32'hFFFF_FFFF;
        else
            special_res = func3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One shift-add step: conditionally add multiplicand to the high half, shift right
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [63:0] mul_prod;
    logic [31:0] mul_final;

    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_step  = {mul_sum, acc_q[31:1]};
    assign mul_prod  = neg64_if(mul_step, neg_q);
    assign mul_final = (op_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];

    // One restoring-divide step: shift next dividend bit into the remainder, trial subtract
    logic [32:0] div_shift;
    logic        div_borrow;
    logic [31:0] div_diff;
    logic [63:0] div_step;
    logic [31:0] div_final;

    assign div_shift  = {acc_q[63:32], acc_q[31]};
    assign div_borrow = (div_shift < {1'b0, opb_q});
    assign div_diff   = div_shift[31:0] - opb_q;
    assign div_step   = div_borrow ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff,        acc_q[30:0], 1'b1};
    assign div_final  = op_q[1] ? neg32_if(div_step[63:32], neg_q)
                                : neg32_if(div_step[31:0],  neg_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            op_q     <= 3'd0;
            opb_q    <= 32'd0;
            acc_q    <= 64'd0;
            neg_q    <= 1'b0;
            result_q <= 32'd0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= 6'd0;
                        op_q  <= func3;
                        if (!func3[2]) begin
                            acc_q   <= {32'd0, mag_b};
                            opb_q   <= mag_a;
                            neg_q   <= sa ^ sb;
                            state_q <= MUL;
                        end else if (div_zero || div_ovf) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            acc_q   <= {32'd0, mag_a};
                            opb_q   <= mag_b;
                            neg_q   <= func3[1] ? sa : (sa ^ sb);
                            state_q <= DIV;
                        end
                    end
                end
                MUL: begin
                    acc_q <= mul_step;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITERATIONS - 1)) begin
                        result_q <= mul_final;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DIV: begin
                    acc_q <= div_step;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(ITERATIONS - 1)) begin
                        result_q <= div_final;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stallRequest = ((state_q == IDLE) && start && !flush) ||
                          (state_q == MUL) || (state_q == DIV);
    assign busy         = (state_q != IDLE);
    assign resultValid  = valid_q;
    assign result       = result_q;

endmodule
